// File: rtl/vga_pkg.sv
// Shared timing defaults, RGB332 colour constants and the RGB332 -> RGB444 expander
// used by the VGA tile scanout engine.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_SCALE    = 20;
    localparam int DEF_COLS     = 32;
    localparam int DEF_ROWS     = 24;

    localparam logic [7:0] BLK = 8'h00;
    localparam logic [7:0] WHT = 8'hFF;
    localparam logic [7:0] RED = 8'hE0;
    localparam logic [7:0] BLU = 8'h03;

    // Replicate the top bits so full-scale RGB332 maps to full-scale 4-bit channels.
    function automatic logic [11:0] rgb332_expand(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

endpackage

// File: rtl/tile_dpram.sv
// Ping-pong tile store: two banks of DEPTH bytes, one write port and one registered
// read port, each with its own bank select.
module tile_dpram #(
    parameter int DEPTH = 768,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [2][DEPTH];

    // Callers guarantee both addresses are below DEPTH.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_bank][rd_addr];
    end

endmodule

// File: rtl/vga_tile_scanout.sv
// VGA scanout engine: sync timing, integer-scaled tile buffer, tear-free bank swap.
// Define GRID_OVERLAY_EN to draw a white line on the first row/column of every tile.
module vga_tile_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SCALE    = DEF_SCALE,
    parameter int COLS     = DEF_COLS,
    parameter int ROWS     = DEF_ROWS,
    parameter int AW       = $clog2(COLS * ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          swap_req,
    output logic          swap_ack,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync,
    output logic [3:0]    red,
    output logic [3:0]    green,
    output logic [3:0]    blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int TXW     = $clog2(H_ACTIVE + 1);
    localparam int TYW     = $clog2(V_ACTIVE + 1);
    localparam int DEPTH   = COLS * ROWS;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SWAP   = VW'(V_ACTIVE);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

    logic [HW-1:0]  hc;
    logic [VW-1:0]  vc;
    logic [SW-1:0]  sub_x, sub_y;
    logic [TXW-1:0] tile_x;
    logic [TYW-1:0] tile_y;

    logic          h_end, v_end, h_act, v_act;
    logic          visible, hs_now, vs_now;
    logic          at_swap, do_swap, wr_ok;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    logic bank_sel, pending;
    logic vis_d1, hs_d1, vs_d1;
    logic [11:0] pix;

    always_comb begin
        h_end   = (hc == H_LAST);
        v_end   = (vc == V_LAST);
        h_act   = (32'(hc) < H_ACTIVE);
        v_act   = (32'(vc) < V_ACTIVE);
        visible = h_act && v_act && (32'(tile_x) < COLS) && (32'(tile_y) < ROWS);
        hs_now  = !((32'(hc) >= H_ACTIVE + H_FP) && (32'(hc) < H_ACTIVE + H_FP + H_SYNC));
        vs_now  = !((32'(vc) >= V_ACTIVE + V_FP) && (32'(vc) < V_ACTIVE + V_FP + V_SYNC));
        rd_addr = visible ? AW'(32'(tile_y) * COLS + 32'(tile_x)) : '0;
        at_swap = (hc == '0) && (vc == V_SWAP);
        do_swap = at_swap && (pending || swap_req);
        wr_ok   = wr_en && (32'(wr_addr) < DEPTH);
    end

    // Tile coordinates are tracked incrementally so no divider is needed on the scan path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc     <= '0;
            vc     <= '0;
            sub_x  <= '0;
            tile_x <= '0;
            sub_y  <= '0;
            tile_y <= '0;
        end else if (h_end) begin
            hc     <= '0;
            sub_x  <= '0;
            tile_x <= '0;
            if (v_end) begin
                vc     <= '0;
                sub_y  <= '0;
                tile_y <= '0;
            end else begin
                vc <= vc + VW'(1);
                if (v_act) begin
                    if (sub_y == SUB_LAST) begin
                        sub_y  <= '0;
                        tile_y <= tile_y + TYW'(1);
                    end else begin
                        sub_y <= sub_y + SW'(1);
                    end
                end
            end
        end else begin
            hc <= hc + HW'(1);
            if (h_act) begin
                if (sub_x == SUB_LAST) begin
                    sub_x  <= '0;
                    tile_x <= tile_x + TXW'(1);
                end else begin
                    sub_x <= sub_x + SW'(1);
                end
            end
        end
    end

    // The swap point sits in vertical blanking, so the read pipeline never straddles a swap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_sel    <= 1'b0;
            pending     <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            bank_sel    <= bank_sel ^ do_swap;
            pending     <= do_swap ? 1'b0 : (pending || swap_req);
            swap_ack    <= do_swap;
            frame_start <= (hc == '0) && (vc == '0);
        end
    end

    tile_dpram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_bank (~bank_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_bank (bank_sel),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef GRID_OVERLAY_EN
    logic grid_d1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grid_d1 <= 1'b0;
        end else begin
            grid_d1 <= visible && ((sub_x == '0) || (sub_y == '0));
        end
    end
`endif

    always_comb begin
        pix = rgb332_expand(BLK);
        if (vis_d1) begin
            pix = rgb332_expand(rd_data);
        end
`ifdef GRID_OVERLAY_EN
        if (grid_d1) begin
            pix = rgb332_expand(WHT);
        end
`endif
    end

    // Syncs travel two stages so they stay aligned with the RAM read plus colour register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vis_d1 <= 1'b0;
            hs_d1  <= 1'b1;
            vs_d1  <= 1'b1;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            red    <= 4'h0;
            green  <= 4'h0;
            blue   <= 4'h0;
        end else begin
            vis_d1              <= visible;
            hs_d1               <= hs_now;
            vs_d1               <= vs_now;
            hsync               <= hs_d1;
            vsync               <= vs_d1;
            {red, green, blue}  <= pix;
        end
    end

endmodule

// File: tb/tb_vga_tile_scanout.sv
// Randomised bench for vga_tile_scanout on a reduced raster with an undersized,
// non-divisible tile grid, checked every cycle against a frame-position model.
module tb_vga_tile_scanout;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 48, VF = 2, VS = 2, VB = 4;
    localparam int SC = 3, NC = 20, NR = 14;
    localparam int DEPTH = NC * NR;
    localparam int AWB = $clog2(DEPTH);
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_en = 1'b0;
    logic [AWB-1:0] wr_addr = '0;
    logic [7:0]     wr_data = 8'h00;
    logic           swap_req = 1'b0;
    logic           swap_ack, frame_start, hsync, vsync;
    logic [3:0]     red, green, blue;

    int cmpCount = 0;
    int failCount = 0;
    int fcnt = 0;

    logic [7:0] mbank [2][DEPTH];
    bit         mknown [2][DEPTH];
    bit         msel = 1'b0;
    bit         mpend = 1'b0;
    bit         expAck = 1'b0;
    bit         expFs = 1'b0;
    int         cyc = 0;

    always #5 clk = ~clk;

    vga_tile_scanout #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SCALE    (SC), .COLS (NC), .ROWS   (NR), .AW   (AWB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    function automatic logic [11:0] expand332(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    // Colour a screen position must show, given the current front bank.
    function automatic logic [11:0] expPix(input int p, output bit known);
        int h, v, idx;
        h = p % HT;
        v = p / HT;
        known = 1'b1;
        if (h < HA && v < VA && (h / SC) < NC && (v / SC) < NR) begin
            idx = (v / SC) * NC + (h / SC);
`ifdef GRID_OVERLAY_EN
            if ((h % SC) == 0 || (v % SC) == 0) return 12'hFFF;
`endif
            known = mknown[msel ? 1 : 0][idx];
            return expand332(mbank[msel ? 1 : 0][idx]);
        end
        return 12'h000;
    endfunction

    // Model: frame position is simply edges-since-reset modulo the frame length.
    always @(posedge clk) begin
        int pos, h, v, back;
        bit doSwap;
        if (!rst) begin
            cyc = 0; msel = 1'b0; mpend = 1'b0; expAck = 1'b0; expFs = 1'b0;
        end else begin
            pos  = cyc % FT;
            h    = pos % HT;
            v    = pos / HT;
            back = msel ? 0 : 1;
            if (wr_en && int'(wr_addr) < DEPTH) begin
                mbank[back][int'(wr_addr)]  = wr_data;
                mknown[back][int'(wr_addr)] = 1'b1;
            end
            doSwap = (h == 0) && (v == VA) && (mpend || swap_req);
            expFs  = (pos == 0);
            expAck = doSwap;
            if (doSwap) begin
                msel  = !msel;
                mpend = 1'b0;
            end else if (swap_req) begin
                mpend = 1'b1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        logic [15:0] act, exv, mask;
        bit known;
        int p, h, v;
        act   = {hsync, vsync, swap_ack, frame_start, red, green, blue};
        known = 1'b1;
        mask  = 16'hFFFF;
        if (!rst) begin
            exv = 16'hC000;
        end else begin
            exv = {2'b11, expAck, expFs, 12'h000};
            if (cyc >= 2) begin
                p = (cyc - 2) % FT;
                h = p % HT;
                v = p / HT;
                exv[15] = !(h >= HA + HF && h < HA + HF + HS);
                exv[14] = !(v >= VA + VF && v < VA + VF + VS);
                exv[11:0] = expPix(p, known);
            end
            if (!known) mask = 16'hF000;
        end
        cmpCount++;
        if ((act & mask) !== (exv & mask)) begin
            failCount++;
            $display("[TB] FAIL cycle_outputs: got %h required %h (hs,vs,ack,fs,rgb) at cyc %0d t=%0t",
                     act & mask, exv & mask, cyc, $time);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exv);
        cmpCount++;
        if (act !== exv) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h required %0h at t=%0t", name, act, exv, $time);
        end
    endtask

    task automatic applyStimulus(input bit we, input int addr, input logic [7:0] data, input bit sreq);
        @(posedge clk);
        #2;
        wr_en    = we;
        wr_addr  = AWB'(addr);
        wr_data  = data;
        swap_req = sreq;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 8'h00, 1'b0);
    endtask

    task automatic waitAck();
        bit seen = 1'b0;
        for (int i = 0; i < 2 * FT; i++) begin
            @(negedge clk);
            if (swap_ack) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("swap_ack_seen", 32'(seen), 32'd1);
    endtask

    task automatic waitFrame();
        bit seen = 1'b0;
        for (int i = 0; i < FT + 20; i++) begin
            @(negedge clk);
            if (frame_start) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("frame_start_seen", 32'(seen), 32'd1);
        fcnt = 0;
    endtask

    // Pixel (x,y) reaches the pins y*HT+x+1 edges after the frame_start sample point.
    task automatic gotoPixel(input int x, input int y);
        int n;
        n = y * HT + x + 1;
        while (fcnt < n) begin
            @(posedge clk);
            fcnt++;
        end
        @(negedge clk);
    endtask

    task automatic checkPixel(input string name, input int x, input int y, input logic [11:0] exv);
        gotoPixel(x, y);
        checkOutput(name, 32'({red, green, blue}), 32'(exv));
    endtask

    initial begin
        int acks;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_hsync", 32'(hsync), 32'd1);
        checkOutput("reset_vsync", 32'(vsync), 32'd1);
        checkOutput("reset_rgb", 32'({red, green, blue}), 32'd0);
        checkOutput("reset_swap_ack", 32'(swap_ack), 32'd0);
        checkOutput("reset_frame_start", 32'(frame_start), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, a, 8'($urandom), 1'b0);
            applyStimulus(1'b0, 0, 8'h00, 1'b1);
            idle();
            waitAck();
        end

        applyStimulus(1'b1, 0, 8'hE0, 1'b0);
        applyStimulus(1'b1, NC + 1, 8'h03, 1'b0);
        applyStimulus(1'b0, 0, 8'h00, 1'b1);
        idle();
        waitAck();
        waitFrame();
        checkPixel("red_px_1_1", 1, 1, 12'hF00);
        checkPixel("red_px_2_2", 2, 2, 12'hF00);
        checkPixel("blu_px_4_4", 4, 4, 12'h00F);
        checkPixel("blu_px_5_5", 5, 5, 12'h00F);
        checkPixel("beyond_cols_px_61_5", 61, 5, 12'h000);
        gotoPixel(67, 5); checkOutput("hsync_px67", 32'(hsync), 32'd1);
        gotoPixel(68, 5); checkOutput("hsync_px68", 32'(hsync), 32'd0);
        gotoPixel(75, 5); checkOutput("hsync_px75", 32'(hsync), 32'd0);
        gotoPixel(76, 5); checkOutput("hsync_px76", 32'(hsync), 32'd1);
        checkPixel("beyond_rows_px_10_43", 10, 43, 12'h000);
        gotoPixel(0, 49); checkOutput("vsync_line49", 32'(vsync), 32'd1);
        gotoPixel(0, 50); checkOutput("vsync_line50", 32'(vsync), 32'd0);
        gotoPixel(0, 52); checkOutput("vsync_line52", 32'(vsync), 32'd1);

        applyStimulus(1'b1, 0, 8'hFF, 1'b0);
        applyStimulus(1'b1, DEPTH, 8'h1C, 1'b0);
        applyStimulus(1'b1, (1 << AWB) - 1, 8'h1C, 1'b0);
        idle();
        waitFrame();
        checkPixel("no_swap_unchanged", 2, 2, 12'hF00);

        waitFrame();
        applyStimulus(1'b0, 0, 8'h00, 1'b1);
        repeat (3) idle();
        applyStimulus(1'b0, 0, 8'h00, 1'b1);
        idle();
        acks = 0;
        for (int i = 0; i < FT; i++) begin
            @(negedge clk);
            if (swap_ack) acks++;
        end
        checkOutput("double_req_one_ack", 32'(acks), 32'd1);
        waitFrame();
        checkPixel("after_swap_white", 2, 2, 12'hFFF);

        for (int i = 0; i < 4 * FT; i++) begin
            applyStimulus(($urandom % 3) == 0, int'($urandom % 512), 8'($urandom), ($urandom % 1500) == 0);
        end
        idle();

        waitFrame();
        gotoPixel(30, 5);
        applyStimulus(1'b0, 0, 8'h00, 1'b1);
        idle();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midreset_hsync", 32'(hsync), 32'd1);
        checkOutput("midreset_vsync", 32'(vsync), 32'd1);
        checkOutput("midreset_rgb", 32'({red, green, blue}), 32'd0);
        checkOutput("midreset_swap_ack", 32'(swap_ack), 32'd0);
        checkOutput("midreset_frame_start", 32'(frame_start), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acks++;
            if (frame_start) break;
        end
        checkOutput("restart_frame_start_delay", 32'(acks), 32'd2);
        acks = 0;
        for (int i = 0; i < FT + 50; i++) begin
            @(negedge clk);
            if (swap_ack) acks++;
        end
        checkOutput("pending_lost_on_reset", 32'(acks), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule

// File: doc/vga_tile_scanout.md
# vga_tile_scanout

Parametrised VGA scanout engine: generates sync timing, scales a COLS×ROWS tile buffer to the active area by an integer SCALE, and drives 4-bit-per-channel RGB. Internal ping-pong tile buffer: the producer writes the back bank while the front bank is displayed, and a request/acknowledge handshake swaps banks only at the start of vertical blanking (tear-free). Sits between the pixel-clock PLL and the VGA pins, replacing the fixed 640×480/÷20 top-level datapath.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- SCALE, 20, screen pixels per tile edge (≥1)
- COLS / ROWS, 32 / 24, tile grid dimensions
- AW, $clog2(COLS*ROWS), tile address width
- clk  in  1  pixel clock (PLL output)
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe into back bank
- wr_addr  in  AW  tile index (row*COLS + col)
- wr_data  in  8  RGB332 tile colour
- swap_req  in  1  request bank swap at next vblank
- swap_ack  out  1  one-cycle pulse when swap performed
- frame_start  out  1  one-cycle pulse at hc=0, vc=0
- hsync / vsync  out  1  active-low syncs
- red / green / blue  out  4  pixel colour, 0 when blanked

## Operation
- hc counts 0..H_TOTAL-1 every cycle, wraps to 0; vc increments on hc wrap, wraps at V_TOTAL-1. H_TOTAL/V_TOTAL = sum of the four widths.
- hsync low for hc ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on vc.
- Tile position from counters, no divider: sub_x counts 0..SCALE-1 during active hc, tile_x increments on sub_x wrap; both clear at hc wrap. sub_y/tile_y same, stepped on hc wrap, cleared at vc wrap.
- Pixel visible iff hc<H_ACTIVE, vc<V_ACTIVE, tile_x<COLS, tile_y<ROWS; otherwise RGB = 0 (covers non-divisible or undersized grids).
- Read address tile_y*COLS+tile_x from front bank (bank_sel); write to !bank_sel. wr_addr ≥ COLS*ROWS ignored.
- Colour expand: red = {d[7:5],d[7]}, green = {d[4:2],d[4]}, blue = {d[1:0],d[1:0]}.
- Swap: swap_req sets pending. At swap point (hc=0, vc=V_ACTIVE), if pending or swap_req: toggle bank_sel, pulse swap_ack, clear pending. swap_req while pending absorbed (one swap). Write in swap cycle lands in pre-swap back bank.
- Reset: hc=vc=0, tile counters 0, bank_sel=0, pending=0; hsync=vsync=1, RGB=0, swap_ack=0, frame_start=0. Buffer contents not reset. Reset mid-frame restarts at hc=vc=0; pending swap lost.

## Timing
- Pipeline: cycle n counters/address; n+1 registered RAM read; n+2 registered RGB. hsync, vsync, visible flag delayed 2 cycles to align with RGB.
- Write-to-display: write visible after next swap_ack; never visible in the current front bank.
- swap_ack and frame_start are combinational of registered state, registered out (aligned with counter cycle, not delayed pipeline).

## Configuration
- GRID_OVERLAY_EN defined: visible pixels with sub_x==0 or sub_y==0 forced to RGB 4'hF each (white tile grid), same 2-cycle latency. Undefined: no overlay logic; RGB purely from buffer.

## Structure
- vga_pkg: timing defaults, colour constants BLK 8'h00, WHT 8'hFF, RED 8'hE0, BLU 8'h03, function rgb332_expand.
- Sub-module tile_dpram: two banks × COLS*ROWS × 8, one write port, one registered read port, bank select on each.

## Test plan
- Reset release, default params -> hsync low for hc 656..751, vsync low for vc 490..491, frame period 800×525 cycles.
- Write RED to addr 0 and BLU to addr 33, swap_req -> swap_ack at hc=0,vc=480; next frame pixels (0..19,0..19) = F,0,0 and (20..39,20..39) = 0,0,F.
- Write without swap -> display unchanged; second swap_req while pending -> exactly one swap_ack.
- SCALE=16, COLS=32 (512 px) -> hc 512..639 output RGB 0.
- wr_addr=768, default params -> no bank change; rst low mid-line -> outputs reset immediately, restart at hc=vc=0.
- GRID_OVERLAY_EN with all-BLK buffer -> hc=0,20,40… and vc=0,20,… lines white, others black.
